fwd_hazard_ctrl: RTL

//  Parametrised forwarding + hazard controller for the 5-stage pipeline. Resolves EX-stage operands

---
 rtl/fwd_hazard_ctrl_pkg.sv | 17 +
 rtl/fwd_hazard_ctrl_port_mux.sv | 48 ++++
 rtl/fwd_hazard_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared definitions for the forwarding / hazard controller.
//   fwd_sel encoding : FWD_RF, FWD_MEM, FWD_WB, FWD_HOLD
//   fsm_state_t      : hazard FSM state encoding (also exported on dbg_state)
package fwd_hazard_ctrl_pkg;

   localparam logic [1:0] FWD_RF   = 2'd0;
   localparam logic [1:0] FWD_MEM  = 2'd1;
   localparam logic [1:0] FWD_WB   = 2'd2;
   localparam logic [1:0] FWD_HOLD = 2'd3;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_LU_STALL = 2'd1,
      ST_MEM_WAIT = 2'd2
   } fsm_state_t;

endpackage

// File: rtl/fwd_hazard_ctrl_port_mux.sv
// fwd_port_mux: operand resolution for one EX source port.
//   ra          : EX source address (0 = hard-wired zero, never forwarded)
//   rd_in       : regfile value from the ID/EX register
//   mem_fwd_ok  : MEM result is forwardable (writes rf, and load data ready if a load)
//   mem_wa/wd   : MEM destination / result
//   wb_we/wa/wd : WB write port
//   hold_v/wa/wd: hold register contents
//   rd_out      : resolved operand
//   sel         : chosen source, priority MEM > WB > HOLD > regfile
module fwd_port_mux
   import fwd_hazard_ctrl_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic [ADDR_W-1:0] ra,
   input  logic [DATA_W-1:0] rd_in,
   input  logic              mem_fwd_ok,
   input  logic [ADDR_W-1:0] mem_wa,
   input  logic [DATA_W-1:0] mem_wd,
   input  logic              wb_we,
   input  logic [ADDR_W-1:0] wb_wa,
   input  logic [DATA_W-1:0] wb_wd,
   input  logic              hold_v,
   input  logic [ADDR_W-1:0] hold_wa,
   input  logic [DATA_W-1:0] hold_wd,
   output logic [DATA_W-1:0] rd_out,
   output logic [1:0]        sel
);

   always_comb begin
      sel    = FWD_RF;
      rd_out = rd_in;
      if (ra != '0) begin
         if (mem_fwd_ok && mem_wa == ra) begin
            sel    = FWD_MEM;
            rd_out = mem_wd;
         end else if (wb_we && wb_wa == ra) begin
            sel    = FWD_WB;
            rd_out = wb_wd;
         end else if (hold_v && hold_wa == ra) begin
            sel    = FWD_HOLD;
            rd_out = hold_wd;
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: EX operand forwarding plus load-use / load-wait hazard control.
//   Inputs : ID source addresses/used flags, EX sources and destination, MEM and WB
//            write-back info, regfile operands from ID/EX.
//   Outputs: ex_rd_out/fwd_sel (combinational per port), stall_if/id/ex/mem,
//            flush_ex/flush_wb, sticky mem_timeout, dbg_state/dbg_hold_v for observation.
// Handshake: there is no valid/ready pair here; stall_* = 1 means "hold that stage
//   register this cycle", flush_* = 1 means "load a bubble into that register".
module fwd_hazard_ctrl
   import fwd_hazard_ctrl_pkg::*;
#(
   parameter int NUM_RD_PORTS = 2,
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 5,
   parameter int LU_STALL_CYC = 1,
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_RD_PORTS*ADDR_W-1:0] id_ra,
   input  logic [NUM_RD_PORTS-1:0]        id_re,
   input  logic [NUM_RD_PORTS*ADDR_W-1:0] ex_ra,
   input  logic [NUM_RD_PORTS*DATA_W-1:0] ex_rd_in,
   input  logic                           ex_we,
   input  logic                           ex_is_load,
   input  logic [ADDR_W-1:0]              ex_wa,
   input  logic                           mem_we,
   input  logic                           mem_is_load,
   input  logic                           mem_data_valid,
   input  logic [ADDR_W-1:0]              mem_wa,
   input  logic [DATA_W-1:0]              mem_wd,
   input  logic                           wb_we,
   input  logic [ADDR_W-1:0]              wb_wa,
   input  logic [DATA_W-1:0]              wb_wd,
   output logic [NUM_RD_PORTS*DATA_W-1:0] ex_rd_out,
   output logic [NUM_RD_PORTS*2-1:0]      fwd_sel,
   output logic                           stall_if,
   output logic                           stall_id,
   output logic                           stall_ex,
   output logic                           stall_mem,
   output logic                           flush_ex,
   output logic                           flush_wb,
   output logic                           mem_timeout,
   output logic [1:0]                     dbg_state,
   output logic                           dbg_hold_v
);

   localparam int WCNT_W = $clog2(MEM_WAIT_MAX + 1);
   localparam int LU_W   = $clog2(LU_STALL_CYC + 1);

   fsm_state_t        state, state_nxt;
   logic [LU_W-1:0]   lu_cnt, lu_nxt;
   logic [WCNT_W-1:0] wait_cnt, wait_nxt, wait_inc;
   logic              hold_v;
   logic [ADDR_W-1:0] hold_wa;
   logic [DATA_W-1:0] hold_wd;
   logic              mem_wait_det, lu_det, mem_fwd_ok;
   logic              full_stall, lu_stall;

   assign mem_fwd_ok   = mem_we && (!mem_is_load || mem_data_valid);
   assign mem_wait_det = mem_we && mem_is_load && !mem_data_valid;
   assign wait_inc     = (wait_cnt == WCNT_W'(MEM_WAIT_MAX)) ? wait_cnt : wait_cnt + WCNT_W'(1);
   assign dbg_state    = state;
   assign dbg_hold_v   = hold_v;

   always_comb begin
      lu_det = 1'b0;
      for (int i = 0; i < NUM_RD_PORTS; i++) begin
         if (id_re[i] && id_ra[i*ADDR_W +: ADDR_W] == ex_wa) lu_det = 1'b1;
      end
      lu_det = lu_det && ex_we && ex_is_load && (ex_wa != '0);
   end

   // Stall outputs are Mealy: asserted on the detecting cycle and while in state.
   // The detecting cycle counts as the first load-use bubble, so LU_STALL only
   // holds the remaining LU_STALL_CYC-1 bubbles. A load wait arising during
   // LU_STALL freezes lu_cnt; a nonzero lu_cnt on exit resumes the load-use stall.
   always_comb begin
      state_nxt  = state;
      lu_nxt     = lu_cnt;
      wait_nxt   = wait_cnt;
      full_stall = 1'b0;
      lu_stall   = 1'b0;
      case (state)
         ST_RUN: begin
            if (mem_wait_det) begin
               full_stall = 1'b1;
               wait_nxt   = wait_inc;
               state_nxt  = ST_MEM_WAIT;
            end else if (lu_det) begin
               lu_stall = 1'b1;
               if (LU_STALL_CYC > 1) begin
                  lu_nxt    = LU_W'(1);
                  state_nxt = ST_LU_STALL;
               end
            end
         end
         ST_LU_STALL: begin
            if (mem_wait_det) begin
               full_stall = 1'b1;
               wait_nxt   = wait_inc;
               state_nxt  = ST_MEM_WAIT;
            end else begin
               lu_stall = 1'b1;
               if (int'(lu_cnt) + 1 >= LU_STALL_CYC) begin
                  lu_nxt    = '0;
                  state_nxt = ST_RUN;
               end else begin
                  lu_nxt = lu_cnt + LU_W'(1);
               end
            end
         end
         ST_MEM_WAIT: begin
            if (!mem_data_valid) begin
               full_stall = 1'b1;
               wait_nxt   = wait_inc;
            end else begin
               wait_nxt  = '0;
               state_nxt = (lu_cnt != '0) ? ST_LU_STALL : ST_RUN;
            end
         end
         default: state_nxt = ST_RUN;
      endcase
      // Reset must drop stalls in the same cycle even if a hazard is still presented.
      if (rst) begin
         full_stall = 1'b0;
         lu_stall   = 1'b0;
      end
   end

   assign stall_if  = full_stall || lu_stall;
   assign stall_id  = full_stall || lu_stall;
   assign stall_ex  = full_stall;
   assign stall_mem = full_stall;
   assign flush_ex  = lu_stall;
   assign flush_wb  = full_stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_RUN;
         lu_cnt      <= '0;
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
      end else begin
         state    <= state_nxt;
         lu_cnt   <= lu_nxt;
         wait_cnt <= wait_nxt;
         if (wait_nxt == WCNT_W'(MEM_WAIT_MAX)) mem_timeout <= 1'b1;
      end
   end

   // Hold register: keeps a WB result that retires while EX is frozen so the
   // frozen EX instruction still sees it once the stall releases.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_v  <= 1'b0;
         hold_wa <= '0;
         hold_wd <= '0;
      end else if (stall_ex) begin
         if (wb_we && wb_wa != '0) begin
            hold_v  <= 1'b1;
            hold_wa <= wb_wa;
            hold_wd <= wb_wd;
         end
      end else begin
         hold_v <= 1'b0;
      end
   end

   for (genvar i = 0; i < NUM_RD_PORTS; i++) begin : g_port
      fwd_port_mux #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W)
      ) u_mux (
         .ra         (ex_ra[i*ADDR_W +: ADDR_W]),
         .rd_in      (ex_rd_in[i*DATA_W +: DATA_W]),
         .mem_fwd_ok (mem_fwd_ok),
         .mem_wa     (mem_wa),
         .mem_wd     (mem_wd),
         .wb_we      (wb_we),
         .wb_wa      (wb_wa),
         .wb_wd      (wb_wd),
         .hold_v     (hold_v),
         .hold_wa    (hold_wa),
         .hold_wd    (hold_wd),
         .rd_out     (ex_rd_out[i*DATA_W +: DATA_W]),
         .sel        (fwd_sel[i*2 +: 2])
      );
   end

endmodule
